// File: rtl/fetch_stage_if.sv
// Fetch-stage bundle: hazard/redirect controls, imem port and IF/ID outputs.
// FETCH_PERF_CNT_EN adds the perf_fetched / perf_stalls counter outputs.
interface fetch_stage_if #(
  parameter int WIDTH   = 32,
  parameter int IMEM_AW = 6
);
  logic               stall;
  logic               redirect_valid;
  logic [WIDTH-1:0]   redirect_pc;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rd;
  logic [WIDTH-1:0]   pc;
  logic [31:0]        id_instr;
  logic [WIDTH-1:0]   id_pcplus4;
  logic               id_valid;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0]        perf_fetched;
  logic [31:0]        perf_stalls;

  modport master (
    output stall, redirect_valid, redirect_pc, imem_rd,
    input  imem_addr, pc, id_instr, id_pcplus4, id_valid, perf_fetched, perf_stalls
  );
  modport slave (
    input  stall, redirect_valid, redirect_pc, imem_rd,
    output imem_addr, pc, id_instr, id_pcplus4, id_valid, perf_fetched, perf_stalls
  );
`else
  modport master (
    output stall, redirect_valid, redirect_pc, imem_rd,
    input  imem_addr, pc, id_instr, id_pcplus4, id_valid
  );
  modport slave (
    input  stall, redirect_valid, redirect_pc, imem_rd,
    output imem_addr, pc, id_instr, id_pcplus4, id_valid
  );
`endif
endinterface

// File: rtl/fetch_stage.sv
// MIPS instruction-fetch stage: PC register, imem addressing and IF/ID register.
// Optional FETCH_PERF_CNT_EN adds saturating fetched/stalled edge counters.
module fetch_stage #(
  parameter int               WIDTH    = 32,
  parameter int               IMEM_AW  = 6,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic          clk,
  input  logic          reset,
  fetch_stage_if.slave  io_fetch
);

  logic [WIDTH-1:0] r_pc;
  logic [31:0]      r_instr;
  logic [WIDTH-1:0] r_pcplus4;
  logic             r_valid;

  logic [WIDTH-1:0] w_pcplus4;
  logic [WIDTH-1:0] w_redirect_pc;

  assign w_pcplus4     = r_pc + WIDTH'(4);
  assign w_redirect_pc = io_fetch.redirect_pc & ~WIDTH'(3);

  // Priority: redirect squashes IF/ID and ignores stall; stall freezes everything.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_pcplus4 <= '0;
      r_valid   <= 1'b0;
    end else if (io_fetch.redirect_valid) begin
      r_pc      <= w_redirect_pc;
      r_instr   <= '0;
      r_pcplus4 <= '0;
      r_valid   <= 1'b0;
    end else if (!io_fetch.stall) begin
      r_pc      <= w_pcplus4;
      r_instr   <= io_fetch.imem_rd;
      r_pcplus4 <= w_pcplus4;
      r_valid   <= 1'b1;
    end
  end

  assign io_fetch.imem_addr  = r_pc[IMEM_AW+1:2];
  assign io_fetch.pc         = r_pc;
  assign io_fetch.id_instr   = r_instr;
  assign io_fetch.id_pcplus4 = r_pcplus4;
  assign io_fetch.id_valid   = r_valid;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_perf_fetched;
  logic [31:0] r_perf_stalls;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_perf_fetched <= '0;
      r_perf_stalls  <= '0;
    end else if (!io_fetch.redirect_valid) begin
      if (io_fetch.stall) begin
        if (r_perf_stalls != 32'hFFFF_FFFF) r_perf_stalls <= r_perf_stalls + 32'd1;
      end else begin
        if (r_perf_fetched != 32'hFFFF_FFFF) r_perf_fetched <= r_perf_fetched + 32'd1;
      end
    end
  end

  assign io_fetch.perf_fetched = r_perf_fetched;
  assign io_fetch.perf_stalls  = r_perf_stalls;
`endif

endmodule
